// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and byte width for the UART transmit arbiter
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search for the first active request at or after rr_ptr
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);
  int idx;
  // Scan offsets from farthest to nearest so the smallest offset from rr_ptr wins.
  always_comb begin
    winner = '0;
    valid = |req;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) winner = ID_W'(idx);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with optional per-requester burst lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    uart_wr_en,
  output logic [BYTE_W-1:0]       uart_data,
  input  logic                    uart_tx_busy
);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, pick_id, load_id, next_ptr;
  logic [CNT_W-1:0] cnt;
  logic pick_valid, lock_hold, load, rr_adv;
  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );
  assign load_id = (state == ST_IDLE) ? pick_id : grant_id;
  assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy = state != ST_IDLE;
  assign uart_wr_en = state == ST_ISSUE;
  assign ack = uart_wr_en ? {{(N_REQ-1){1'b0}}, 1'b1} << grant_id : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    load = 1'b0;
    rr_adv = 1'b0;
    err_timeout = 1'b0;
    case (state)
      ST_IDLE: if (pick_valid && !uart_tx_busy) begin
        state_n = ST_ISSUE;
        load = 1'b1;
      end
      ST_ISSUE: state_n = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (uart_tx_busy) state_n = ST_WAIT_DONE;
      else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
        err_timeout = 1'b1;
        rr_adv = 1'b1;
        state_n = ST_IDLE;
      end
      ST_WAIT_DONE: if (!uart_tx_busy) begin
        load = lock_hold && req[grant_id];
        rr_adv = !load;
        state_n = load ? ST_ISSUE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // A locked requester reloads its next byte and lock from the same grant, bypassing arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      grant_id <= '0;
      uart_data <= '0;
      lock_hold <= 1'b0;
      cnt <= '0;
    end else begin
      if (load) begin
        uart_data <= req_data[load_id*BYTE_W +: BYTE_W];
        grant_id <= load_id;
        lock_hold <= lock[load_id];
      end
      if (rr_adv) rr_ptr <= next_ptr;
      cnt <= (state == ST_ISSUE) ? '0 : (state == ST_WAIT_BUSY) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the UART transmit arbiter with a simple transmitter busy model
module tb_uart_tx_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, lock = '0;
  logic [31:0] req_data = '0;
  logic [3:0] ack;
  logic [1:0] grant_id;
  logic busy, err_timeout, uart_wr_en, uart_tx_busy;
  logic [7:0] uart_data;
  logic model_en = 1'b1, model_busy = 1'b0, pend = 1'b0, force_busy = 1'b0;
  int hold = 20, left = 0, cyc = 0, checks = 0, errors = 0;
  int log_id[$], log_cyc[$];
  logic [7:0] log_dat[$];

  uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .uart_wr_en(uart_wr_en), .uart_data(uart_data), .uart_tx_busy(uart_tx_busy)
  );

  assign uart_tx_busy = model_busy | force_busy;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // transmitter: busy rises one cycle after a write strobe and stays high for 'hold' cycles
  initial forever begin
    @(negedge clk);
    if (pend) begin model_busy = 1'b1; left = hold; pend = 1'b0; end
    else if (model_busy) begin left--; if (left <= 0) model_busy = 1'b0; end
    if (model_en && uart_wr_en) pend = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (uart_wr_en) begin
      checks++;
      if (uart_tx_busy !== 1'b0 || ack !== (4'b1 << grant_id)) begin
        errors++;
        $display("FAIL wr_protocol: tx_busy=%b ack=%b grant_id=%0d, required tx_busy=0 ack=%b", uart_tx_busy, ack, grant_id, 4'b1 << grant_id);
      end
      log_id.push_back(int'(grant_id)); log_dat.push_back(uart_data); log_cyc.push_back(cyc);
    end else if (ack !== 4'b0) begin
      checks++; errors++;
      $display("FAIL ack_without_wr: ack=%b, required 0000", ack);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(); @(negedge clk); #1; endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; req_data = '0; force_busy = 1'b0;
    step(); rst = 1'b0; step();
    log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b, required 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; step();
    checks++;
    if ({ack, grant_id, busy, err_timeout, uart_wr_en, uart_data} !== 17'd0) begin
      errors++; $display("FAIL reset_values: ack=%b gid=%0d busy=%b err=%b wr=%b data=%h, required all 0", ack, grant_id, busy, err_timeout, uart_wr_en, uart_data);
    end
    rst = 1'b0; step();
    checks++;
    if (busy !== 1'b0 || uart_wr_en !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b wr=%b, required 0 0", busy, uart_wr_en); end
  endtask

  task automatic test_single();
    hold = 20; model_en = 1'b1; do_reset();
    req_data[23:16] = 8'hA5; req = 4'b0100;
    step();
    checks++;
    if (uart_wr_en !== 1'b1 || uart_data !== 8'hA5 || ack !== 4'b0100 || grant_id !== 2'd2) begin
      errors++; $display("FAIL single_issue: wr=%b data=%h ack=%b gid=%0d, required 1 a5 0100 2", uart_wr_en, uart_data, ack, grant_id);
    end
    req = '0;
    for (int i = 0; i < 10 && uart_tx_busy !== 1'b1; i++) step();
    for (int i = 0; i < 40 && uart_tx_busy !== 1'b0; i++) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: busy=%b, required 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd2) begin errors++; $display("FAIL single_busy_fall: busy=%b gid=%0d, required 0 2", busy, grant_id); end
    repeat (3) step();
    checks++;
    if (log_id.size() != 1) begin errors++; $display("FAIL single_count: writes=%0d, required 1", log_id.size()); end
  endtask

  task automatic test_round_robin();
    int exp_id[6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0] exp_dat[6] = '{8'hA0, 8'hB1, 8'hD3, 8'hA0, 8'hB1, 8'hD3};
    hold = 4; model_en = 1'b1; do_reset();
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; req = 4'b1011;
    for (int i = 0; i < 400 && log_id.size() < 6; i++) step();
    req = '0;
    wait_idle("rr");
    repeat (3) step();
    checks++;
    if (log_id.size() != 6) begin errors++; $display("FAIL rr_count: writes=%0d, required 6", log_id.size()); end
    for (int i = 0; i < 6 && i < log_id.size(); i++) begin
      checks++;
      if (log_id[i] != exp_id[i] || log_dat[i] !== exp_dat[i]) begin
        errors++; $display("FAIL rr_order[%0d]: id=%0d data=%h, required %0d %h", i, log_id[i], log_dat[i], exp_id[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_lock_burst();
    int exp_id[4] = '{0, 0, 0, 1};
    logic [7:0] exp_dat[4] = '{8'h01, 8'h02, 8'h03, 8'hF1};
    int exp_gap[3];
    hold = 4; model_en = 1'b1; do_reset();
    exp_gap = '{hold + 2, hold + 2, hold + 3};
    req_data[7:0] = 8'h01; req_data[15:8] = 8'hF1; lock = 4'b0001; req = 4'b0011;
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 100; i++) begin step(); if (ack[0]) break; end
      if (b < 3) begin req_data[7:0] = 8'(b + 1); lock[0] = (b + 1 < 3); end
      else req[0] = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin step(); if (ack[1]) break; end
    req = '0; lock = '0;
    wait_idle("lock");
    checks++;
    if (log_id.size() != 4) begin errors++; $display("FAIL lock_count: writes=%0d, required 4", log_id.size()); end
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      checks++;
      if (log_id[i] != exp_id[i] || log_dat[i] !== exp_dat[i]) begin
        errors++; $display("FAIL lock_order[%0d]: id=%0d data=%h, required %0d %h", i, log_id[i], log_dat[i], exp_id[i], exp_dat[i]);
      end
    end
    for (int i = 0; i < 3 && i + 1 < log_cyc.size(); i++) begin
      checks++;
      if (log_cyc[i+1] - log_cyc[i] != exp_gap[i]) begin
        errors++; $display("FAIL lock_gap[%0d]: cycles=%0d, required %0d", i, log_cyc[i+1] - log_cyc[i], exp_gap[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int c;
    model_en = 1'b0; do_reset();
    req_data[7:0] = 8'h5A; req_data[15:8] = 8'h6B; req = 4'b0011;
    for (int i = 0; i < 10 && uart_wr_en !== 1'b1; i++) step();
    c = cyc;
    checks++;
    if (grant_id !== 2'd0 || uart_data !== 8'h5A) begin errors++; $display("FAIL to_first: gid=%0d data=%h, required 0 5a", grant_id, uart_data); end
    req = 4'b0010;
    for (int i = 0; i < 40 && err_timeout !== 1'b1; i++) step();
    checks++;
    if (err_timeout !== 1'b1 || cyc - c != TO) begin errors++; $display("FAIL to_delay: err=%b cycles=%0d, required 1 %0d", err_timeout, cyc - c, TO); end
    step();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_pulse: err=%b busy=%b, required 0 0", err_timeout, busy); end
    step();
    checks++;
    if (uart_wr_en !== 1'b1 || grant_id !== 2'd1 || uart_data !== 8'h6B) begin
      errors++; $display("FAIL to_next: wr=%b gid=%0d data=%h, required 1 1 6b", uart_wr_en, grant_id, uart_data);
    end
    req = '0;
    wait_idle("to");
    model_en = 1'b1;
  endtask

  task automatic test_async_reset();
    int n;
    hold = 20; model_en = 1'b1; do_reset();
    req_data[23:16] = 8'h11; req = 4'b0100;
    for (int i = 0; i < 10; i++) begin step(); if (ack[2]) break; end
    req = '0;
    wait_idle("ar_pre");
    req_data[7:0] = 8'h22; req_data[31:24] = 8'h44; req = 4'b1001;
    for (int i = 0; i < 10; i++) begin step(); if (ack !== 4'b0) break; end
    checks++;
    if (grant_id !== 2'd3) begin errors++; $display("FAIL ar_rr: gid=%0d, required 3", grant_id); end
    req = 4'b0001;
    for (int i = 0; i < 10 && uart_tx_busy !== 1'b1; i++) step();
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, grant_id, busy, err_timeout, uart_wr_en, uart_data} !== 17'd0) begin
      errors++; $display("FAIL ar_clear: ack=%b gid=%0d busy=%b err=%b wr=%b data=%h, required all 0", ack, grant_id, busy, err_timeout, uart_wr_en, uart_data);
    end
    n = log_id.size();
    step(); rst = 1'b0;
    for (int i = 0; i < 40 && uart_tx_busy !== 1'b0; i++) step();
    checks++;
    if (log_id.size() != n || busy !== 1'b0) begin errors++; $display("FAIL ar_blocked: writes=%0d busy=%b, required %0d 0", log_id.size(), busy, n); end
    step();
    checks++;
    if (uart_wr_en !== 1'b1 || grant_id !== 2'd0 || uart_data !== 8'h22) begin
      errors++; $display("FAIL ar_regrant: wr=%b gid=%0d data=%h, required 1 0 22", uart_wr_en, grant_id, uart_data);
    end
    req = '0;
    wait_idle("ar");
  endtask

  task automatic test_blocking();
    hold = 4; model_en = 1'b1; do_reset();
    force_busy = 1'b1; req_data[15:8] = 8'h9C; req = 4'b0010;
    repeat (6) step();
    checks++;
    if (log_id.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL blk_hold: writes=%0d busy=%b, required 0 0", log_id.size(), busy); end
    force_busy = 1'b0;
    step();
    checks++;
    if (uart_wr_en !== 1'b1 || grant_id !== 2'd1 || uart_data !== 8'h9C) begin
      errors++; $display("FAIL blk_release: wr=%b gid=%0d data=%h, required 1 1 9c", uart_wr_en, grant_id, uart_data);
    end
    req = '0;
    wait_idle("blk");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_timeout();
    test_async_reset();
    test_blocking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
